systolic_scheduler: RTL and testbench

- Sequences one full alignment job through the N-PE systolic array.
- Splits the query into ceil(q_len/N) passes. Per pass: loads N query bases into the PEs, streams the whole target, then waits for the array to drain.
- Sits between the host/job registers and the array. Reads the query and target base buffers and drives the array's S/T/s_update/valid/ack/new_seq inputs.

---
 rtl/systolic_scheduler_pkg.sv | 29 ++
 rtl/systolic_scheduler_feed_pipe.sv | 41 ++++
 rtl/systolic_scheduler.sv | 175 +++++++++++++++++
 tb/tb_systolic_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_scheduler_pkg.sv
// Shared sizes, state encoding and pass-count helper for the systolic scheduler.
package systolic_scheduler_pkg;

    localparam int unsigned N             = 8;
    localparam int unsigned LOG_N         = 3;
    localparam int unsigned BP_WIDTH      = 2;
    localparam int unsigned LEN_WIDTH     = 10;
    localparam int unsigned PASS_WIDTH    = 4;
    localparam int unsigned DRAIN_TIMEOUT = 1023;
    localparam int unsigned MAX_PASSES    = 1 << PASS_WIDTH;
    localparam int unsigned WD_WIDTH      = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_NEXT   = 3'd5
    } sched_state_t;

    // Number of N-wide passes needed to cover len query bases (one spare bit so 2^PASS_WIDTH+1 is visible).
    function automatic logic [LEN_WIDTH:0] calc_npass(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, len} + (LEN_WIDTH + 1)'(N - 1);
        return sum >> LOG_N;
    endfunction

endpackage

// File: rtl/systolic_scheduler_feed_pipe.sv
// One-cycle alignment stage so array strobes line up with 1-cycle-latency buffer reads.
module systolic_scheduler_feed_pipe
    import systolic_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                reset_i,
    input  logic                i_s_update,
    input  logic                i_s_in_range,
    input  logic                i_valid,
    input  logic [BP_WIDTH-1:0] i_q_data,
    input  logic [BP_WIDTH-1:0] i_t_data,
    output logic [BP_WIDTH-1:0] o_s_base,
    output logic [BP_WIDTH-1:0] o_t_base,
    output logic                o_s_update,
    output logic                o_valid
);

    logic r_s_update;
    logic r_s_keep;
    logic r_valid;

    // Delay the load/stream qualifiers by the buffer read latency.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_s_update <= 1'b0;
            r_s_keep   <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_s_update <= i_s_update;
            r_s_keep   <= i_s_update & i_s_in_range;
            r_valid    <= i_valid;
        end
    end

    // Buffer data arrives already registered; gate it so padding and idle cycles carry zero.
    assign o_s_update = r_s_update;
    assign o_valid    = r_valid;
    assign o_s_base   = r_s_keep ? i_q_data : '0;
    assign o_t_base   = r_valid  ? i_t_data : '0;

endmodule

// File: rtl/systolic_scheduler.sv
// Sequences an alignment job through the N-PE systolic array, one N-base query slice per pass.
module systolic_scheduler
    import systolic_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  q_len,
    input  logic [LEN_WIDTH-1:0]  t_len,
    output logic                  sched_busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  q_addr,
    input  logic [BP_WIDTH-1:0]   q_data,
    output logic [LEN_WIDTH-1:0]  t_addr,
    input  logic [BP_WIDTH-1:0]   t_data,
    output logic [BP_WIDTH-1:0]   sa_S,
    output logic [BP_WIDTH-1:0]   sa_T,
    output logic                  sa_s_update,
    output logic                  sa_valid,
    output logic                  sa_ack,
    output logic                  sa_new_seq,
    input  logic                  sa_busy,
    output logic [PASS_WIDTH-1:0] pass_idx
);

    sched_state_t          r_state;
    logic [LEN_WIDTH-1:0]  r_q_len;
    logic [LEN_WIDTH-1:0]  r_t_len;
    logic [PASS_WIDTH-1:0] r_last_pass;
    logic [PASS_WIDTH-1:0] r_pass;
    logic [LOG_N-1:0]      r_k;
    logic [LEN_WIDTH-1:0]  r_q_addr;
    logic [LEN_WIDTH-1:0]  r_t_addr;
    logic [WD_WIDTH-1:0]   r_wd;
    logic                  r_seen_busy;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_ack;
    logic                  r_new_seq;

    logic [LEN_WIDTH:0]    w_npass;
    logic                  w_start_ok;
    logic                  w_load;
    logic                  w_in_range;
    logic                  w_stream;

    assign w_npass    = calc_npass(q_len);
    assign w_start_ok = (q_len != '0) && (t_len != '0) &&
                        (w_npass <= (LEN_WIDTH + 1)'(MAX_PASSES));
    assign w_load     = (r_state == ST_LOAD);
    assign w_in_range = (r_q_addr < r_q_len);
    assign w_stream   = (r_state == ST_STREAM);

    // Job sequencer: state, address counters, drain watchdog and strobes.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_q_len     <= '0;
            r_t_len     <= '0;
            r_last_pass <= '0;
            r_pass      <= '0;
            r_k         <= '0;
            r_q_addr    <= '0;
            r_t_addr    <= '0;
            r_wd        <= '0;
            r_seen_busy <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_ack       <= 1'b0;
            r_new_seq   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_ack     <= 1'b0;
            r_new_seq <= 1'b0;
            if (sa_busy) begin
                r_seen_busy <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_q_len     <= q_len;
                            r_t_len     <= t_len;
                            r_last_pass <= PASS_WIDTH'(w_npass - (LEN_WIDTH + 1)'(1));
                            r_pass      <= '0;
                            r_ack       <= 1'b1;
                            r_new_seq   <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_ARM;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    r_seen_busy <= 1'b0;
                    r_q_addr    <= LEN_WIDTH'(r_pass) << LOG_N;
                    r_k         <= '0;
                    r_state     <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_k <= r_k + LOG_N'(1);
                    if (r_k == LOG_N'(N - 1)) begin
                        r_t_addr <= '0;
                        r_state  <= ST_STREAM;
                    end else begin
                        r_q_addr <= r_q_addr + LEN_WIDTH'(1);
                    end
                end
                ST_STREAM: begin
                    if (r_t_addr == r_t_len - LEN_WIDTH'(1)) begin
                        r_wd    <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_t_addr <= r_t_addr + LEN_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_seen_busy && !sa_busy) begin
                        r_state <= ST_NEXT;
                    end else if (r_wd == WD_WIDTH'(DRAIN_TIMEOUT - 1)) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + WD_WIDTH'(1);
                    end
                end
                ST_NEXT: begin
                    if (r_pass == r_last_pass) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_pass  <= r_pass + PASS_WIDTH'(1);
                        r_ack   <= 1'b1;
                        r_state <= ST_ARM;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    systolic_scheduler_feed_pipe u_sched_feed_pipe (
        .clk          (clk),
        .reset_i      (reset_i),
        .i_s_update   (w_load),
        .i_s_in_range (w_in_range),
        .i_valid      (w_stream),
        .i_q_data     (q_data),
        .i_t_data     (t_data),
        .o_s_base     (sa_S),
        .o_t_base     (sa_T),
        .o_s_update   (sa_s_update),
        .o_valid      (sa_valid)
    );

    assign sched_busy = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign q_addr     = r_q_addr;
    assign t_addr     = r_t_addr;
    assign sa_ack     = r_ack;
    assign sa_new_seq = r_new_seq;
    assign pass_idx   = r_pass;

endmodule

// File: tb/tb_systolic_scheduler.sv
// Self-checking bench for systolic_scheduler: table vectors, corner sequences, random jobs vs a stream-level model.
module tb_systolic_scheduler;
    import systolic_scheduler_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic                  start;
    logic [LEN_WIDTH-1:0]  q_len;
    logic [LEN_WIDTH-1:0]  t_len;
    logic                  sched_busy;
    logic                  done;
    logic                  error;
    logic [LEN_WIDTH-1:0]  q_addr;
    logic [BP_WIDTH-1:0]   q_data;
    logic [LEN_WIDTH-1:0]  t_addr;
    logic [BP_WIDTH-1:0]   t_data;
    logic [BP_WIDTH-1:0]   sa_S;
    logic [BP_WIDTH-1:0]   sa_T;
    logic                  sa_s_update;
    logic                  sa_valid;
    logic                  sa_ack;
    logic                  sa_new_seq;
    logic                  sa_busy;
    logic [PASS_WIDTH-1:0] pass_idx;

    systolic_scheduler dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .start       (start),
        .q_len       (q_len),
        .t_len       (t_len),
        .sched_busy  (sched_busy),
        .done        (done),
        .error       (error),
        .q_addr      (q_addr),
        .q_data      (q_data),
        .t_addr      (t_addr),
        .t_data      (t_data),
        .sa_S        (sa_S),
        .sa_T        (sa_T),
        .sa_s_update (sa_s_update),
        .sa_valid    (sa_valid),
        .sa_ack      (sa_ack),
        .sa_new_seq  (sa_new_seq),
        .sa_busy     (sa_busy),
        .pass_idx    (pass_idx)
    );

    always #5 clk = ~clk;

    // Query/target buffers with one cycle of read latency.
    logic [BP_WIDTH-1:0] qmem [0:1023];
    logic [BP_WIDTH-1:0] tmem [0:1023];
    always @(posedge clk) begin
        q_data <= qmem[q_addr];
        t_data <= tmem[t_addr];
    end

    // Array model: busy from first stream base until busy_tail cycles after the last one.
    int busy_mode;
    int busy_tail;
    int busy_cnt;
    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sa_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (busy_mode == 1 && sa_valid) begin
            sa_busy  <= 1'b1;
            busy_cnt <= busy_tail;
        end else if (sa_busy) begin
            if (busy_cnt == 0) sa_busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    int got_s[$];
    int got_t[$];
    int got_pass[$];
    int got_ns[$];
    int viol, n_done, n_err, busy_seen, cyc, last_valid_cyc, err_cyc;

    typedef struct {
        int ql;
        int tl;
        int exp_ok;
        int exp_npass;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_obs();
        got_s.delete();
        got_t.delete();
        got_pass.delete();
        got_ns.delete();
        viol = 0; n_done = 0; n_err = 0; busy_seen = 0;
        last_valid_cyc = 0; err_cyc = 0;
    endtask

    // Record what the array sees this cycle; called at the falling edge.
    task automatic sample();
        cyc++;
        if (sa_s_update) got_s.push_back(int'(sa_S));
        else if (sa_S != '0) viol++;
        if (sa_valid) begin
            got_t.push_back(int'(sa_T));
            last_valid_cyc = cyc;
        end else if (sa_T != '0) viol++;
        if (sa_ack) begin
            got_pass.push_back(int'(pass_idx));
            got_ns.push_back(int'(sa_new_seq));
        end else if (sa_new_seq) viol++;
        if (done) n_done++;
        if (error) begin
            n_err++;
            err_cyc = cyc;
        end
        if (sched_busy) busy_seen = 1;
    endtask

    task automatic pulse_start(input int ql, input int tl);
        start = 1'b1;
        q_len = LEN_WIDTH'(ql);
        t_len = LEN_WIDTH'(tl);
        @(negedge clk);
        sample();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int k;
        k = 0;
        while (n_done + n_err == 0 && k < budget) begin
            @(negedge clk);
            sample();
            k++;
        end
        check({tag, "_finished"}, int'(n_done + n_err > 0), 1);
        repeat (3) begin
            @(negedge clk);
            sample();
        end
    endtask

    function automatic int model_npass(input int ql);
        return (ql + N - 1) / N;
    endfunction

    function automatic int model_ok(input int ql, input int tl);
        return (ql != 0 && tl != 0 && model_npass(ql) <= (1 << PASS_WIDTH)) ? 1 : 0;
    endfunction

    // Run one job and compare every observed stream with the model's expectation.
    task automatic run_job(input int ql, input int tl, input int exp_ok, input int exp_npass,
                           input string tag);
        int exp_s[$];
        int exp_t[$];
        int mism;
        int lim;
        clear_obs();
        pulse_start(ql, tl);
        if (exp_ok == 0) check({tag, "_error_next_cycle"}, n_err, 1);
        wait_end(30000, tag);
        check({tag, "_done"}, n_done, exp_ok);
        check({tag, "_error"}, n_err, 1 - exp_ok);
        check({tag, "_busy_seen"}, busy_seen, exp_ok);
        check({tag, "_ack_count"}, got_pass.size(), exp_ok ? exp_npass : 0);
        check({tag, "_idle_strobe_violations"}, viol, 0);
        check({tag, "_busy_after"}, int'(sched_busy), 0);
        if (exp_ok != 0) begin
            for (int p = 0; p < exp_npass; p++) begin
                for (int k = 0; k < N; k++)
                    exp_s.push_back((p * N + k < ql) ? int'(qmem[p * N + k]) : 0);
                for (int j = 0; j < tl; j++)
                    exp_t.push_back(int'(tmem[j]));
            end
            check({tag, "_s_count"}, got_s.size(), exp_s.size());
            check({tag, "_t_count"}, got_t.size(), exp_t.size());
            mism = 0;
            lim = (got_s.size() < exp_s.size()) ? got_s.size() : exp_s.size();
            for (int i = 0; i < lim; i++) if (got_s[i] != exp_s[i]) mism++;
            check({tag, "_s_data_mismatches"}, mism, 0);
            mism = 0;
            lim = (got_t.size() < exp_t.size()) ? got_t.size() : exp_t.size();
            for (int i = 0; i < lim; i++) if (got_t[i] != exp_t[i]) mism++;
            check({tag, "_t_data_mismatches"}, mism, 0);
            mism = 0;
            for (int i = 0; i < got_pass.size(); i++) begin
                if (got_pass[i] != i) mism++;
                if (got_ns[i] != ((i == 0) ? 1 : 0)) mism++;
            end
            check({tag, "_pass_seq_mismatches"}, mism, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(sched_busy), 0);
        check({tag, "_strobes"}, int'({done, error, sa_s_update, sa_valid, sa_ack, sa_new_seq}), 0);
        check({tag, "_addrs"}, int'(q_addr) + int'(t_addr), 0);
        check({tag, "_bases"}, int'({sa_S, sa_T}), 0);
        check({tag, "_pass_idx"}, int'(pass_idx), 0);
    endtask

    vec_t vecs[9];

    initial begin
        int k;
        int ql;
        int tl;
        reset_i   = 1'b1;
        start     = 1'b0;
        q_len     = '0;
        t_len     = '0;
        busy_mode = 1;
        busy_tail = 3;
        cyc       = 0;
        for (int i = 0; i < 1024; i++) begin
            qmem[i] = BP_WIDTH'($urandom);
            tmem[i] = BP_WIDTH'($urandom);
        end
        clear_obs();

        vecs[0] = '{8,   5, 1, 1};
        vecs[1] = '{20,  4, 1, 3};
        vecs[2] = '{0,   5, 0, 0};
        vecs[3] = '{5,   0, 0, 0};
        vecs[4] = '{129, 3, 0, 0};
        vecs[5] = '{128, 3, 1, 16};
        vecs[6] = '{1,   1, 1, 1};
        vecs[7] = '{9,   7, 1, 2};
        vecs[8] = '{0,   0, 0, 0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_i = 1'b0;
        repeat (2) @(negedge clk);

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            busy_tail = 2 + i;
            run_job(vecs[i].ql, vecs[i].tl, vecs[i].exp_ok, vecs[i].exp_npass,
                    $sformatf("vec%0d", i));
        end

        // Drain watchdog expiry, with an ignored start during STREAM.
        busy_mode = 0;
        clear_obs();
        pulse_start(8, 3);
        k = 0;
        while (got_t.size() == 0 && k < 100) begin
            @(negedge clk);
            sample();
            k++;
        end
        check("timeout_stream_reached", int'(got_t.size() > 0), 1);
        pulse_start(0, 0);
        wait_end(3000, "timeout");
        check("timeout_errors", n_err, 1);
        check("timeout_done", n_done, 0);
        check("timeout_latency", err_cyc - last_valid_cyc, DRAIN_TIMEOUT);
        check("timeout_t_count", got_t.size(), 3);
        check("timeout_acks", got_pass.size(), 1);
        check("timeout_busy_after", int'(sched_busy), 0);
        busy_mode = 1;

        // Asynchronous reset in the middle of STREAM.
        clear_obs();
        pulse_start(16, 10);
        k = 0;
        while (got_t.size() < 3 && k < 100) begin
            @(negedge clk);
            sample();
            k++;
        end
        check("midreset_stream_reached", int'(got_t.size() >= 3), 1);
        #2 reset_i = 1'b1;
        #1 check_all_zero("midreset");
        clear_obs();
        @(negedge clk);
        sample();
        @(negedge clk);
        sample();
        reset_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            sample();
        end
        check("midreset_no_done", n_done, 0);
        check("midreset_no_error", n_err, 0);
        check("midreset_no_busy", busy_seen, 0);
        run_job(8, 5, 1, 1, "after_reset");

        // Random jobs against the model.
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 256; j++) begin
                qmem[j] = BP_WIDTH'($urandom);
                tmem[j] = BP_WIDTH'($urandom);
            end
            ql = int'($urandom_range(0, 136));
            tl = int'($urandom_range(0, 24));
            busy_tail = int'($urandom_range(0, 12));
            run_job(ql, tl, model_ok(ql, tl), model_npass(ql), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
